// File: rtl/accum_alu.sv
// Handshaked ADD/SUB/shift-add MUL/accumulate unit with carry and overflow flags.
// Define ACCUM_SAT_EN to saturate the accumulator instead of wrapping it.
module accum_alu #(
  parameter int WIDTH     = 4,
  parameter int ACC_WIDTH = 2*WIDTH
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [1:0]           op,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [ACC_WIDTH-1:0] result,
  output logic                 carry,
  output logic                 overflow,
  output logic                 busy
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_MUL = 2'b10,
    OP_ACC = 2'b11
  } op_t;

  state_t               state_q, state_d;
  logic [ACC_WIDTH-1:0] acc_q, acc_d;
  logic [ACC_WIDTH-1:0] result_q, result_d;
  logic                 carry_q, carry_d;
  logic                 overflow_q, overflow_d;
  logic [ACC_WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0]     mplier_q, mplier_d;
  logic [CW-1:0]        cnt_q, cnt_d;

  logic                 accept;
  logic [WIDTH:0]       add_sum;
  logic [WIDTH-1:0]     sub_diff;
  logic [ACC_WIDTH:0]   acc_sum;
  logic [ACC_WIDTH-1:0] acc_next;

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q == MUL);
  assign accept    = in_valid & in_ready;
  assign result    = result_q;
  assign carry     = carry_q;
  assign overflow  = overflow_q;

  // Datapath values for the single-cycle ops, evaluated straight off the inputs
  always_comb begin
    add_sum  = {1'b0, a} + {1'b0, b};
    sub_diff = a - b;
    acc_sum  = {1'b0, acc_q} + {{(ACC_WIDTH+1-WIDTH){1'b0}}, a};
`ifdef ACCUM_SAT_EN
    acc_next = acc_sum[ACC_WIDTH] ? {ACC_WIDTH{1'b1}} : acc_sum[ACC_WIDTH-1:0];
`else
    acc_next = acc_sum[ACC_WIDTH-1:0];
`endif
  end

  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    result_d   = result_q;
    carry_d    = carry_q;
    overflow_d = overflow_q;
    mcand_d    = mcand_q;
    mplier_d   = mplier_q;
    cnt_d      = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          unique case (op_t'(op))
            OP_ADD: begin
              result_d   = ACC_WIDTH'(add_sum);
              carry_d    = add_sum[WIDTH];
              overflow_d = 1'b0;
              state_d    = DONE;
            end
            OP_SUB: begin
              result_d   = ACC_WIDTH'(sub_diff);
              carry_d    = (a < b);
              overflow_d = 1'b0;
              state_d    = DONE;
            end
            OP_MUL: begin
              // result_q doubles as the partial product; out_valid is low meanwhile
              result_d   = '0;
              mcand_d    = ACC_WIDTH'(a);
              mplier_d   = b;
              cnt_d      = '0;
              carry_d    = 1'b0;
              overflow_d = 1'b0;
              state_d    = MUL;
            end
            OP_ACC: begin
              if (b[0]) begin
                acc_d      = ACC_WIDTH'(a);
                overflow_d = 1'b0;
              end else begin
                acc_d      = acc_next;
                overflow_d = acc_sum[ACC_WIDTH];
              end
              result_d = b[0] ? ACC_WIDTH'(a) : acc_next;
              carry_d  = 1'b0;
              state_d  = DONE;
            end
            default: state_d = IDLE;
          endcase
        end
      end
      MUL: begin
        if (mplier_q[0]) result_d = result_q + mcand_q;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == CW'(WIDTH - 1)) state_d = DONE;
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      acc_q      <= '0;
      result_q   <= '0;
      carry_q    <= 1'b0;
      overflow_q <= 1'b0;
      mcand_q    <= '0;
      mplier_q   <= '0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      result_q   <= result_d;
      carry_q    <= carry_d;
      overflow_q <= overflow_d;
      mcand_q    <= mcand_d;
      mplier_q   <= mplier_d;
      cnt_q      <= cnt_d;
    end
  end

endmodule
